counter_h: RTL and testbench

5-bit synchronous up/down counter with synchronous load, count enable and terminal-count carry output. It is a general-purpose counting primitive that feeds timers and sequencers in the datapath. Direction is selected per cycle by `D`. `O_Carry` flags the terminal count so counters can be cascaded.

---
 rtl/counter_h.sv | 76 +++++++
 tb/tb_counter_h.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_h.sv
// counter_h - WIDTH-bit synchronous up/down counter with synchronous load,
// count enable and a combinational terminal-count carry flag.
//
// Parameters:
//   WIDTH      - counter width in bits (default 5)
//   LOAD_VALUE - value written to Out when Load is asserted (default 0)
//
// Ports:
//   Clk      in   rising-edge clock
//   Reset_n  in   asynchronous active-low reset, clears Out to 0
//   D        in   direction: 1 = up, 0 = down
//   E        in   count enable: 1 = count, 0 = hold
//   Load     in   synchronous load of LOAD_VALUE (priority over E/D)
//   Out      out  current count, straight from the register
//   O_Carry  out  terminal-count flag, combinational from Out/D/E/Load
//
// Build option:
//   COUNTER_H_SATURATE_EN - when defined, the count holds at the terminal
//   value instead of wrapping; O_Carry uses the same formula either way.

module counter_h #(
  parameter int unsigned          WIDTH      = 5,
  parameter logic [WIDTH-1:0]     LOAD_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             D,
  input  logic             E,
  input  logic             Load,
  output logic [WIDTH-1:0] Out,
  output logic             O_Carry
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] count_next;
  logic             at_top;
  logic             at_bottom;

  assign at_top    = (Out == MAX_VAL);
  assign at_bottom = (Out == '0);

  always_comb begin
    count_next = Out;
    if (Load) begin
      count_next = LOAD_VALUE;
    end else if (E) begin
      if (D) begin
`ifdef COUNTER_H_SATURATE_EN
        count_next = at_top ? Out : Out + ONE;
`else
        count_next = Out + ONE;
`endif
      end else begin
`ifdef COUNTER_H_SATURATE_EN
        count_next = at_bottom ? Out : Out - ONE;
`else
        count_next = Out - ONE;
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Out <= '0;
    end else begin
      Out <= count_next;
    end
  end

  // Flags the cycle whose next enabled edge would wrap (or saturate) the count.
  assign O_Carry = E & ~Load & ((D & at_top) | (~D & at_bottom));

endmodule

// File: tb/tb_counter_h.sv
// tb_counter_h - self-checking bench for counter_h (default parameters).
// A plain integer model tracks the expected count; O_Carry is predicted from
// the model value and the current inputs.

module tb_counter_h;

  localparam int WIDTH = 5;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             reset_n;
  logic             d;
  logic             e;
  logic             load;
  logic [WIDTH-1:0] out;
  logic             o_carry;

  int checks;
  int errors;
  int model;

  counter_h #(
    .WIDTH      (WIDTH),
    .LOAD_VALUE ('0)
  ) dut (
    .Clk     (clk),
    .Reset_n (reset_n),
    .D       (d),
    .E       (e),
    .Load    (load),
    .Out     (out),
    .O_Carry (o_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int next_value(int cur, logic ld, logic en, logic dir);
    if (ld) return 0;
    if (!en) return cur;
`ifdef COUNTER_H_SATURATE_EN
    if (dir) return (cur == MAXV) ? MAXV : cur + 1;
    return (cur == 0) ? 0 : cur - 1;
`else
    if (dir) return (cur + 1) % (MAXV + 1);
    return (cur + MAXV) % (MAXV + 1);
`endif
  endfunction

  function automatic logic exp_carry(int cur, logic ld, logic en, logic dir);
    if (ld || !en) return 1'b0;
    return dir ? (cur == MAXV) : (cur == 0);
  endfunction

  // Advance one rising edge with the currently driven inputs; returns #1 after it.
  task automatic step();
    int nxt;
    nxt = next_value(model, load, e, d);
    @(posedge clk);
    #1;
    if (reset_n) model = nxt;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; d = 1'b0; e = 1'b1; load = 1'b0;
    model = 0;
    #3;
    checks++;
    if (out !== WIDTH'(0)) begin
      errors++;
      $display("FAIL reset_out: got %0d expected 0", out);
    end
    checks++;
    if (o_carry !== 1'b1) begin
      errors++;
      $display("FAIL reset_carry_down: got %b expected 1", o_carry);
    end
    d = 1'b1;
    #1;
    checks++;
    if (o_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_carry_up: got %b expected 0", o_carry);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== WIDTH'(0)) begin
      errors++;
      $display("FAIL reset_hold_edge: got %0d expected 0", out);
    end
  endtask

  task automatic test_load_count_up();
    reset_n = 1'b1;
    d = 1'b1; e = 1'b1; load = 1'b1;
    step();
    checks++;
    if (out !== WIDTH'(0)) begin
      errors++;
      $display("FAIL load_out: got %0d expected 0", out);
    end
    load = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (out !== WIDTH'(model) || model != i) begin
        errors++;
        $display("FAIL count_up_%0d: got %0d expected %0d", i, out, i);
      end
      checks++;
      if (o_carry !== 1'b0) begin
        errors++;
        $display("FAIL count_up_carry_%0d: got %b expected 0", i, o_carry);
      end
    end
  endtask

  task automatic test_down_wrap();
    d = 1'b0; e = 1'b1; load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out !== WIDTH'(model)) begin
        errors++;
        $display("FAIL down_%0d: got %0d expected %0d", i, out, model);
      end
      checks++;
      if (o_carry !== exp_carry(model, load, e, d)) begin
        errors++;
        $display("FAIL down_carry_%0d: got %b expected %b", i, o_carry,
                 exp_carry(model, load, e, d));
      end
    end
  endtask

  task automatic test_up_wrap();
    load = 1'b1; e = 1'b1; d = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < MAXV; i++) step();
    checks++;
    if (out !== WIDTH'(model) || model != MAXV) begin
      errors++;
      $display("FAIL up_top: got %0d expected %0d", out, MAXV);
    end
    checks++;
    if (o_carry !== 1'b1) begin
      errors++;
      $display("FAIL up_top_carry: got %b expected 1", o_carry);
    end
    step();
    checks++;
    if (out !== WIDTH'(model)) begin
      errors++;
      $display("FAIL up_wrap: got %0d expected %0d", out, model);
    end
    checks++;
    if (o_carry !== exp_carry(model, load, e, d)) begin
      errors++;
      $display("FAIL up_wrap_carry: got %b expected %b", o_carry,
               exp_carry(model, load, e, d));
    end
  endtask

  task automatic test_enable_hold();
    load = 1'b1; e = 1'b1; d = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) step();
    e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = ~d;
      step();
      checks++;
      if (out !== WIDTH'(7) || model != 7) begin
        errors++;
        $display("FAIL hold_%0d: got %0d expected 7", i, out);
      end
      checks++;
      if (o_carry !== 1'b0) begin
        errors++;
        $display("FAIL hold_carry_%0d: got %b expected 0", i, o_carry);
      end
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; e = 1'b1; d = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (out !== WIDTH'(12)) begin
      errors++;
      $display("FAIL pre_reset: got %0d expected 12", out);
    end
    // Pulse reset between edges; Out must clear without a clock edge.
    #1;
    reset_n = 1'b0;
    model = 0;
    #1;
    checks++;
    if (out !== WIDTH'(0)) begin
      errors++;
      $display("FAIL async_reset: got %0d expected 0", out);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (out !== WIDTH'(1) || model != 1) begin
      errors++;
      $display("FAIL resume_after_reset: got %0d expected 1", out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      d    = 1'($urandom_range(0, 1));
      e    = ($urandom_range(0, 9) < 8);
      load = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (o_carry !== exp_carry(model, load, e, d)) begin
        errors++;
        $display("FAIL rand_carry_%0d: got %b expected %b (out=%0d d=%b e=%b load=%b)",
                 i, o_carry, exp_carry(model, load, e, d), out, d, e, load);
      end
      if ($urandom_range(0, 49) == 0) begin
        reset_n = 1'b0;
        model = 0;
        #1;
        reset_n = 1'b1;
      end
      step();
      checks++;
      if (out !== WIDTH'(model)) begin
        errors++;
        $display("FAIL rand_out_%0d: got %0d expected %0d", i, out, model);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_count_up();
    test_down_wrap();
    test_up_wrap();
    test_enable_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
